// File: rtl/dmx_pkg.sv
// dmx_pkg: sizing helpers shared by the stream demux and its per-channel FIFO.
package dmx_pkg;
  function automatic int n_ch(input int sel_bits);
    return 1 << sel_bits;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int lane_off(input int lane, input int data_bits);
    return lane * data_bits;
  endfunction
endpackage

// File: rtl/dmx_fifo.sv
// dmx_fifo: single-clock synchronous FIFO, one per demux channel.
module dmx_fifo
  import dmx_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_BITS-1:0]    wdata,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic [DATA_BITS-1:0]    head
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full     = count_q == CW'(DEPTH);
    empty    = count_q == '0;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    count    = count_q;
    head     = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is not reset: a zero count already hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/dmx_stream.sv
// dmx_stream: valid/ready demux routing one input stream to per-channel FIFOs,
// with an all-or-nothing broadcast mode.
module dmx_stream
  import dmx_pkg::*;
#(
  parameter int SEL_BITS  = 1,
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_BITS-1:0]                   in_data,
  input  logic [SEL_BITS-1:0]                    in_sel,
  input  logic                                   in_bcast,
  output logic [n_ch(SEL_BITS)-1:0]              out_valid,
  input  logic [n_ch(SEL_BITS)-1:0]              out_ready,
  output logic [n_ch(SEL_BITS)*DATA_BITS-1:0]    out_data,
  output logic                                   busy
);
  localparam int N = n_ch(SEL_BITS);
  logic [N-1:0] full, empty, target, push_en;
  logic [N-1:0][cnt_w(DEPTH)-1:0] count;
  logic [N-1:0][DATA_BITS-1:0] head;
  // Space comes only from registered FIFO state, so out_ready never reaches in_ready.
  always_comb begin
    target   = in_bcast ? '1 : N'(1) << in_sel;
    in_ready = !rst_n || (in_bcast ? &(~full) : !full[in_sel]);
    push_en  = (in_valid && in_ready && rst_n) ? target : '0;
    busy     = |out_valid;
  end
  for (genvar g = 0; g < N; g++) begin : g_ch
    dmx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_en[g]),
      .pop   (out_ready[g]),
      .wdata (in_data),
      .full  (full[g]),
      .empty (empty[g]),
      .count (count[g]),
      .head  (head[g])
    );
    assign out_valid[g] = count[g] != '0;
    assign out_data[lane_off(g, DATA_BITS) +: DATA_BITS] = empty[g] ? '0 : head[g];
  end
endmodule

// File: tb/tb_dmx_stream.sv
// tb_dmx_stream: scoreboard bench for dmx_stream with SEL_BITS=2, DEPTH=2.
module tb_dmx_stream;
  localparam int SB = 2;
  localparam int DB = 32;
  localparam int DP = 2;
  localparam int N  = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_bcast, busy;
  logic [DB-1:0] in_data;
  logic [SB-1:0] in_sel;
  logic [N-1:0] out_valid, out_ready;
  logic [N*DB-1:0] out_data;
  logic [DB-1:0] sb_q [N][$];
  int checks = 0;
  int failures = 0;

  dmx_stream #(.SEL_BITS(SB), .DATA_BITS(DB), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic b,
                      input logic [3:0] r, input logic [31:0] d);
    logic exp_rdy, all_sp, acc;
    logic [31:0] exp_d;
    in_valid = v; in_sel = s; in_bcast = b; out_ready = r; in_data = d;
    @(negedge clk);
    all_sp = 1'b1;
    for (int i = 0; i < N; i++) if (sb_q[i].size() >= DP) all_sp = 1'b0;
    exp_rdy = !rst_n || (b ? all_sp : (sb_q[s].size() < DP));
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    out_ready = ~r;
    #1;
    check("ready_indep", {31'd0, in_ready}, {31'd0, exp_rdy});
    out_ready = r;
    #1;
    for (int i = 0; i < N; i++) begin
      exp_d = sb_q[i].size() != 0 ? sb_q[i][0] : 32'd0;
      check($sformatf("valid%0d", i), {31'd0, out_valid[i]}, {31'd0, sb_q[i].size() != 0});
      check($sformatf("data%0d", i), out_data[i*DB +: DB], exp_d);
    end
    check("busy", {31'd0, busy},
          {31'd0, (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0});
    acc = v && exp_rdy && rst_n;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sb_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sb_q[i].size() != 0 && r[i]) void'(sb_q[i].pop_front());
        if (acc && (b || s == 2'(i))) sb_q[i].push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, r, 32'hFFFF_FFFF);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(4'h0, 2);
    rst_n = 1'b1;
    idle(4'h0, 1);
    // Unicast fill of ch2, then drain in order.
    step(1'b1, 2'd2, 1'b0, 4'h0, 32'hA0);
    step(1'b1, 2'd2, 1'b0, 4'h0, 32'hA1);
    step(1'b1, 2'd2, 1'b0, 4'h0, 32'hA2);
    step(1'b0, 2'd0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 2'd2, 1'b0, 4'h4, 32'h0);
    step(1'b0, 2'd2, 1'b0, 4'h4, 32'h0);
    idle(4'h0, 1);
    // Isolation: ch1 full and stalled while ch0 streams.
    step(1'b1, 2'd1, 1'b0, 4'h0, 32'hB0);
    step(1'b1, 2'd1, 1'b0, 4'h0, 32'hB1);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 1'b0, 4'h1, 32'h10 + i);
    idle(4'h1, 2);
    idle(4'h2, 2);
    // Broadcast into empty channels, then blocked by full ch3.
    step(1'b1, 2'd0, 1'b1, 4'h0, 32'hDEAD_BEEF);
    step(1'b0, 2'd0, 1'b0, 4'h7, 32'h0);
    step(1'b1, 2'd3, 1'b0, 4'h0, 32'hC3);
    step(1'b1, 2'd1, 1'b1, 4'h0, 32'h1234_5678);
    step(1'b1, 2'd0, 1'b1, 4'h0, 32'h1234_5678);
    idle(4'hF, 3);
    // Simultaneous push/pop on ch0 across pointer wrap.
    step(1'b1, 2'd0, 1'b0, 4'h0, 32'h54);
    for (int i = 0; i < 2 * DP + 1; i++) step(1'b1, 2'd0, 1'b0, 4'h1, 32'h55 + i);
    idle(4'h1, 2);
    // Reset mid-operation with a beat offered.
    step(1'b1, 2'd0, 1'b0, 4'h0, 32'h70);
    step(1'b1, 2'd1, 1'b0, 4'h0, 32'h71);
    step(1'b1, 2'd1, 1'b0, 4'h0, 32'h72);
    rst_n = 1'b0;
    step(1'b1, 2'd0, 1'b0, 4'h0, 32'h99);
    rst_n = 1'b1;
    idle(4'h0, 2);
    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), $urandom);
    idle(4'hF, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmx_stream.md
# dmx_stream

Handshaked, buffered successor to the combinational one-hot demux. Routes a valid/ready input stream to one of 2**SEL_BITS output channels, or to all of them in broadcast mode. Each channel has its own DEPTH-entry FIFO, so a stalled consumer blocks only traffic addressed to it. It sits between a producer (e.g. the memory-write or I/O request path) and multiple independent sinks that may back-pressure.

## Interface
Parameters:
- SEL_BITS, default 1: select width; channel count N = 2**SEL_BITS (1..4 supported).
- DATA_BITS, default 32: payload width.
- DEPTH, default 2: per-channel FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  DATA_BITS  payload.
- in_sel  in  SEL_BITS  destination channel; ignored when in_bcast=1.
- in_bcast  in  1  deliver the beat to every channel.
- out_valid  out  N  per-channel head valid.
- out_ready  in  N  per-channel consumer ready.
- out_data  out  N*DATA_BITS  channel i head at [i*DATA_BITS +: DATA_BITS].
- busy  out  1  any channel non-empty.

## Operation
- Per-channel state: count_i (0..DEPTH), wr_ptr_i, rd_ptr_i (log2(DEPTH) bits, wrap modulo DEPTH).
- Space_i = (count_i < DEPTH). Space depends only on registered state, never on out_ready, so there is no combinational out_ready→in_ready path.
- in_ready is Space[in_sel] when in_bcast=0, and AND of all Space_i when in_bcast=1. in_ready may depend combinationally on in_sel/in_bcast.
- Push: on an accepted beat, write in_data at wr_ptr of the target channel (all channels in broadcast), then increment wr_ptr and count.
- Pop_i: when out_valid[i] && out_ready[i], increment rd_ptr_i and decrement count_i.
- Push and pop on the same channel in the same cycle leave count unchanged and both pointers advance.
- A full channel rejects a push even if it pops that cycle.
- out_valid[i] = (count_i != 0).
- out_data slice i = entry at rd_ptr_i when count_i != 0, else all-zero (unused lanes read zero).
- busy = OR of out_valid.
- out_ready[i] while out_valid[i]=0 is ignored.
- in_data/in_sel/in_bcast are don't-care when in_valid=0.
- Ordering: strict FIFO per channel; no ordering relation between channels.
- Broadcast is all-or-nothing: never a partial delivery.

## Timing
- Reset (rst_n=0 at a clock edge): all counts and pointers go to 0. Buffered data is discarded. Stored entries need not be cleared.
- During and after reset: out_valid=0, out_data=0, busy=0. in_ready is 1 (all channels empty) while rst_n=0, but nothing is accepted.
- Reset mid-transfer flushes every channel in that cycle. A beat offered in the reset cycle is dropped.
- Latency: a beat accepted at edge k is visible at out_valid/out_data after edge k. There is no same-cycle fall-through.
- Throughput: 1 beat/cycle sustained into any channel whose consumer holds out_ready=1 (DEPTH≥2).
- Full boundary: count=DEPTH → in_ready=0 for that channel until a pop has registered (one-cycle bubble after the pop).
- Empty boundary: count=0 → out_valid=0, and pointer wrap is transparent.

## Structure
- Shared package dmx_pkg:
  - localparam helpers: channel count N = 2**SEL_BITS, pointer width $clog2(DEPTH), count width $clog2(DEPTH+1).
  - function for the lane slice offset.
- Sub-module dmx_fifo #(DATA_BITS, DEPTH):
  - single-clock synchronous FIFO: push, pop, full, empty, count, head data, synchronous active-low reset.
  - instantiated N times in a generate loop.
- The top level holds only:
  - push-enable decode: one-hot of in_sel, or all-ones for broadcast, gated by accept;
  - in_ready selection;
  - output zero-masking.

## Test plan
- Unicast fill: SEL_BITS=2, DEPTH=2, out_ready=0. Push 0xA0,0xA1 to ch2 → ch2 accepts both, then in_ready=0 with in_sel=2 and 1 with in_sel=0. Then out_ready[2]=1 → 0xA0 then 0xA1 in order; in_ready=1 on the cycle after the first pop.
- Isolation: ch1 full and stalled, ch0 out_ready=1. Stream 0x10..0x17 to ch0 → all 8 delivered at 1/cycle, ch1 contents unchanged.
- Broadcast: all channels empty. Push 0xDEADBEEF with in_bcast=1 → next cycle out_valid=4'b1111, every lane 0xDEADBEEF. With ch3 full, broadcast gives in_ready=0 and no channel count changes.
- Simultaneous push/pop: ch0 count=1, push 0x55 while popping the head → count stays 1, head becomes 0x55. Run 2·DEPTH+1 beats to exercise pointer wrap.
- Reset mid-operation: ch0 and ch1 partially full, assert rst_n=0 for one edge while in_valid=1 → out_valid=0, out_data=0, busy=0 next cycle. The offered beat never appears.
- Random: random valid/ready/sel/bcast over 10k cycles against a per-channel queue scoreboard → no loss, duplication or reordering; in_ready never depends on out_ready.
